// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and default frame geometry.
// Used by the window generator and the downstream pooling stage.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_WIDTH  = 8;
    localparam int DEF_IMG_HEIGHT = 8;

    typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel stream in, 2x2 window out, each with valid/ready.
// master = stream source / window sink, slave = window generator.
interface pool_window_gen_if
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_sof;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] win_tl;
    logic [DATA_WIDTH-1:0] win_tr;
    logic [DATA_WIDTH-1:0] win_bl;
    logic [DATA_WIDTH-1:0] win_br;
    logic                  win_valid;
    logic                  win_ready;
    logic                  frame_done;

    modport master (
        output pix_in, pix_sof, pix_valid, win_ready,
        input  pix_ready, win_tl, win_tr, win_bl, win_br,
        input  win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_sof, pix_valid, win_ready,
        output pix_ready, win_tl, win_tr, win_bl, win_br,
        output win_valid, frame_done
    );

endinterface

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two async read ports.
// Contents are intentionally not reset.
module pool_line_buffer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_IMG_WIDTH,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 pooling windows.
// Even rows fill the line buffer; odd rows pair with it.
module pool_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input logic              clk,
    input logic              rst,
    pool_window_gen_if.slave bus
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col;
    logic [CW-1:0]         cur_col;
    logic [CW-1:0]         nxt_col;
    logic [RW-1:0]         row;
    logic [RW-1:0]         cur_row;
    logic [DATA_WIDTH-1:0] tl_hold;
    logic [DATA_WIDTH-1:0] tr_hold;
    logic [DATA_WIDTH-1:0] bl_hold;
    logic [DATA_WIDTH-1:0] rd_lo;
    logic [DATA_WIDTH-1:0] rd_hi;
    logic                  acc;
    logic                  wr_en;
    logic                  complete;
    logic                  last;

    assign bus.pix_ready = !bus.win_valid || bus.win_ready;
    assign acc = bus.pix_valid && bus.pix_ready;

    // Start-of-frame forces this pixel to (0,0), dropping any partial window.
    assign cur_col  = bus.pix_sof ? '0 : col;
    assign cur_row  = bus.pix_sof ? '0 : row;
    assign nxt_col  = cur_col + CW'(1);
    assign wr_en    = acc && !cur_row[0];
    assign complete = acc && cur_row[0] && cur_col[0];
    assign last     = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .AW         (CW)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_addr   (cur_col),
        .wr_data   (bus.pix_in),
        .rd_addr_a (cur_col),
        .rd_addr_b (nxt_col),
        .rd_data_a (rd_lo),
        .rd_data_b (rd_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= nxt_col;
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tl_hold <= '0;
            tr_hold <= '0;
            bl_hold <= '0;
        end else if (acc && cur_row[0] && !cur_col[0]) begin
            tl_hold <= rd_lo;
            tr_hold <= rd_hi;
            bl_hold <= bus.pix_in;
        end
    end

    // A window can only complete while pix_ready, so a stalled one is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.win_tl     <= '0;
            bus.win_tr     <= '0;
            bus.win_bl     <= '0;
            bus.win_br     <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= complete && last;
            if (complete) begin
                bus.win_tl    <= tl_hold;
                bus.win_tr    <= tr_hold;
                bus.win_bl    <= bl_hold;
                bus.win_br    <= bus.pix_in;
                bus.win_valid <= 1'b1;
            end else if (bus.win_ready) begin
                bus.win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Upstream stage of the CNN accelerator datapath.
- Accepts a raster-order pixel stream (one pixel per handshake) and produces non-overlapping 2x2 windows for the pooling/activation stage: top-left, top-right, bottom-left, bottom-right, matching its four window inputs in that order.
- Buffers one image row internally and emits one window per 2x2 block, with valid/ready backpressure and an end-of-frame pulse.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 8, pixels per row; must be even and >= 2.
- IMG_HEIGHT, 8, rows per frame; must be even and >= 2.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- pix_in  in  DATA_WIDTH  input pixel.
- pix_sof  in  1  start-of-frame marker, qualified by pix_valid.
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- win_tl  out  DATA_WIDTH  window pixel (row r, col c).
- win_tr  out  DATA_WIDTH  window pixel (r, c+1).
- win_bl  out  DATA_WIDTH  window pixel (r+1, c).
- win_br  out  DATA_WIDTH  window pixel (r+1, c+1).
- win_valid  out  1  window outputs are valid.
- win_ready  in  1  downstream consumes the window.
- frame_done  out  1  one-cycle pulse; the last window of the frame is being presented.

Behaviour:
- Handshakes:
  - Input accept: acc = pix_valid && pix_ready.
  - Output consume: win_valid && win_ready.
- Reset values:
  - win_valid=0, frame_done=0, win_* = 0.
  - col=0, row=0, held registers 0.
  - Line buffer contents are not reset; they are don't-care.
- pix_ready = !win_valid || win_ready. This is combinational. Accept and consume may occur in the same cycle.
- Counters:
  - col is in 0..IMG_WIDTH-1 and row is in 0..IMG_HEIGHT-1, each $clog2 width.
  - col increments on acc and wraps to 0, which increments row.
  - row wraps to 0 after IMG_HEIGHT-1.
- pix_sof on acc: the pixel is treated as (row 0, col 0) regardless of counter state; the counters resync and any partial window is discarded. pix_sof when the counters are already at 0,0 is a no-op.
- Even row, on acc: linebuf[col] <= pix_in.
- Odd row, even col, on acc:
  - bl_hold <= pix_in.
  - tl_hold <= linebuf[col].
  - tr_hold <= linebuf[col+1].
- Odd row, odd col, on acc (window complete):
  - Next cycle: win_tl=tl_hold, win_tr=tr_hold, win_bl=bl_hold, win_br=pix_in, win_valid=1.
  - Latency is one cycle from the completing pixel's acceptance.
- Window hold: win_* and win_valid stay stable while win_valid && !win_ready. win_valid clears on consume unless a new window completes in the same cycle, in which case the new window is loaded and valid stays 1.
- frame_done: asserted in the same cycle win_valid first presents the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It is a single cycle even if that window is stalled.
- No arithmetic on pixel data; values pass through unmodified.
- Reset mid-frame: all state returns to reset values immediately. A pending window is dropped and the next accepted pixel is (0,0).
- pix_valid low: no state change except window consume.

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH default.
  - Pixel typedef (logic [DATA_WIDTH-1:0]).
  - Default IMG_WIDTH/IMG_HEIGHT constants, shared with the downstream stage.
- One sub-module: pool_line_buffer.
  - IMG_WIDTH x DATA_WIDTH storage.
  - One write port plus two combinational read addresses (col, col+1).
  - No reset on storage.

Test Plan:
- 4x4 frame of pixels 0..15, win_ready=1 -> windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15) in order. Each appears one cycle after pixels 5, 7, 13, 15 respectively. frame_done is asserted with the last window only.
- Same frame with win_ready held 0 for 3 cycles after the first window -> win_* stays (0,1,4,5) and pix_ready=0 for those cycles. Then the window is consumed and the stream resumes with no loss or duplication.
- Back-to-back frames, second frame pixels 100..115 with pix_sof on 100 -> first window of frame 2 is (100,101,104,105). No stale frame-1 data.
- pix_sof asserted on a pixel at (row 1, col 2) mid-frame -> counters resync, the partial window is discarded, and the next four windows match a fresh frame starting at that pixel.
- rst pulsed while win_valid=1 and row=1 -> win_valid=0 and frame_done=0 immediately. The next frame 0..15 produces the correct four windows.
- pix_valid toggled every other cycle -> same four windows with the same values; frame_done count = 1.
